regfile_dump_ctrl: RTL and testbench
====================================

# regfile_dump_ctrl

Debug-path controller that shares the register file's read port 1 between the pipeline and a debug dump sequence. On a start pulse it walks all registers in address order, captures each 32-bit value from the synchronous read port and streams it to the debug UART transmitter as 4 bytes, LSB first, over a valid/ready handshake. It sits between the decode stage, the register file and the UART TX. Its busy flag is the stall/write-gate request to the hazard unit.

## Interface
- REG_ADDRS_BITS, 5, register address width
- PROC_BITS, 32, register data width; must be 32, as each word is sent as 4 bytes
- REG_COUNT, 2**REG_ADDRS_BITS, number of registers dumped
- clk  in  1  system clock, all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  dump request; sampled only in IDLE
- i_pipe_read_register_1  in  REG_ADDRS_BITS  pipeline read address, port 1
- i_pipe_read_register_2  in  REG_ADDRS_BITS  pipeline read address, port 2
- o_read_register_1  out  REG_ADDRS_BITS  address to register file port 1
- o_read_register_2  out  REG_ADDRS_BITS  address to register file port 2
- i_read_data_1  in  PROC_BITS  register file port 1 data; valid the cycle after the address edge
- o_busy  out  1  dump in progress; pipeline must stall and gate register writes
- o_tx_data  out  8  byte to UART TX
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  UART TX accepts the byte this cycle
- o_done  out  1  one-cycle pulse: dump complete

## Operation
- States: IDLE, ADDR, WAIT, SEND, DONE.
- IDLE:
  - o_read_register_1/2 = i_pipe_read_register_1/2 (combinational pass-through).
  - i_start=1 → ADDR, with index=0 and byte_idx=0.
- ADDR:
  - o_read_register_1 = o_read_register_2 = index.
  - The register file samples the address at the closing edge.
  - → WAIT.
- WAIT:
  - Address still driven as index; i_read_data_1 now holds registers[index].
  - word_buf ← i_read_data_1 at the closing edge; → SEND.
- SEND:
  - o_tx_valid=1, o_tx_data = word_buf[8*byte_idx +: 8].
  - On o_tx_valid & i_tx_ready:
    - If byte_idx<3: byte_idx++.
    - Else if index==REG_COUNT-1: → DONE.
    - Else: index++, byte_idx=0, → ADDR.
  - Without the handshake, o_tx_data and o_tx_valid hold unchanged.
- DONE: o_done=1 for this single cycle; → IDLE.
- o_busy=1 in every state except IDLE; address mux in every non-IDLE state selects index.
- i_start outside IDLE is ignored; no queuing.
- index is REG_ADDRS_BITS wide; termination is decided by compare, never by wrap-around.
- Register writes during a dump are prevented upstream via o_busy. Each captured value is the register content at that register's ADDR edge.

## Timing
- Reset (rst=1 at an edge): state=IDLE, index=0, byte_idx=0, word_buf=0, o_tx_valid=0, o_tx_data=0, o_done=0, o_busy=0. Address outputs follow the pipeline inputs next cycle.
- Reset mid-dump: IDLE next cycle. An unacknowledged byte is dropped and no further bytes are sent. o_done is not pulsed.
- i_start=1 in IDLE at cycle 0:
  - o_busy=1 from cycle 1 (ADDR).
  - WAIT in cycle 2.
  - First o_tx_valid in cycle 3.
- Per register, with i_tx_ready held high: 6 cycles (ADDR, WAIT, 4×SEND).
- Full dump, i_tx_ready always high: last byte accepted in cycle 192, o_done in cycle 193, IDLE/o_busy=0 in cycle 194.
- Each low cycle of i_tx_ready during SEND adds exactly one cycle.
- All outputs other than the IDLE address pass-through are functions of registered state only; no combinational path from i_tx_ready.

## Test plan
- Reset: assert rst 2 cycles mid-traffic → all outputs at reset values. o_read_register_1/2 equal pipeline inputs (e.g. 5'd7, 5'd12).
- Full dump: preload register i = 32'hC0DE0000|i, pulse i_start, i_tx_ready=1.
  - Byte stream: i, 8'h00, 8'hDE, 8'hC0 for i=0..31 (128 bytes).
  - First valid in cycle 3, o_done in cycle 193, o_busy low in cycle 194.
- Backpressure: drop i_tx_ready for 5 cycles while byte 2 of register 3 (8'hDE) is presented.
  - Byte and valid held stable throughout; no byte lost or duplicated.
  - o_done delayed by exactly 5 cycles.
- Start while busy: pulse i_start at cycles 10 and 50 of a dump → single 128-byte stream, single o_done.
- Reset mid-dump: rst during SEND of register 9 → o_tx_valid=0 next cycle, IDLE, no o_done.
  - A new i_start then dumps from register 0.
- Address mux: during a dump, change i_pipe_read_register_1/2 every cycle → o_read_register_1/2 track index only. After DONE they return to pass-through.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - debug dump of the register file over a byte stream
// Walks every register via read port 1 and emits each word as 4 bytes, LSB first.
module regfile_dump_ctrl #(
  parameter int REG_ADDRS_BITS = 5,
  parameter int PROC_BITS      = 32,
  parameter int REG_COUNT      = 2**REG_ADDRS_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [REG_ADDRS_BITS-1:0] i_pipe_read_register_1,
  input  logic [REG_ADDRS_BITS-1:0] i_pipe_read_register_2,
  output logic [REG_ADDRS_BITS-1:0] o_read_register_1,
  output logic [REG_ADDRS_BITS-1:0] o_read_register_2,
  input  logic [PROC_BITS-1:0]      i_read_data_1,
  output logic                      o_busy,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [REG_ADDRS_BITS-1:0] LAST_INDEX = REG_ADDRS_BITS'(REG_COUNT - 1);

  state_t                    state_q, state_d;
  logic [REG_ADDRS_BITS-1:0] index_q, index_d;
  logic [1:0]                byte_idx_q, byte_idx_d;
  logic [PROC_BITS-1:0]      word_buf_q, word_buf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_ADDR;
          index_d    = '0;
          byte_idx_d = '0;
        end
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: begin
        // Register file answers one cycle after the ADDR edge.
        word_buf_d = i_read_data_1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        if (i_tx_ready) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
          end else begin
            index_d    = index_q + 1'b1;
            byte_idx_d = '0;
            state_d    = ST_ADDR;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy            = (state_q != ST_IDLE);
    o_tx_valid        = (state_q == ST_SEND);
    o_done            = (state_q == ST_DONE);
    o_tx_data         = '0;
    o_read_register_1 = index_q;
    o_read_register_2 = index_q;
    if (state_q == ST_SEND) begin
      o_tx_data = word_buf_q[{byte_idx_q, 3'b000} +: 8];
    end
    // Only the idle address path is combinational from inputs.
    if (state_q == ST_IDLE) begin
      o_read_register_1 = i_pipe_read_register_1;
      o_read_register_2 = i_pipe_read_register_2;
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - self-checking bench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [4:0]  i_pipe_read_register_1, i_pipe_read_register_2;
  logic [4:0]  o_read_register_1, o_read_register_2;
  logic [31:0] i_read_data_1;
  logic        o_busy, o_tx_valid, i_tx_ready, o_done;
  logic [7:0]  o_tx_data;

  int passed = 0;
  int total  = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  regfile_dump_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_start                (i_start),
    .i_pipe_read_register_1 (i_pipe_read_register_1),
    .i_pipe_read_register_2 (i_pipe_read_register_2),
    .o_read_register_1      (o_read_register_1),
    .o_read_register_2      (o_read_register_2),
    .i_read_data_1          (i_read_data_1),
    .o_busy                 (o_busy),
    .o_tx_data              (o_tx_data),
    .o_tx_valid             (o_tx_valid),
    .i_tx_ready             (i_tx_ready),
    .o_done                 (o_done)
  );

  // Synchronous-read register file model
  always_ff @(posedge clk) i_read_data_1 <= rf[o_read_register_1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] p1, p2;
    logic       chk;
    logic [4:0] e1, e2;
    logic       busy, valid, done;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[6];

  task automatic run_dump(input int stall_start, input int stall_len, input bit extra_starts,
                          input bit wiggle, input int exp_done);
    int cyc = 0;
    int nbytes = 0;
    int first_valid = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    int idle_cyc = -1;
    int exp_idx;
    logic [31:0] word;
    logic [7:0]  exp_byte;
    i_start = 1'b1;
    i_tx_ready = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      if (cyc == 1) chk("busy_at_cycle1", o_busy, 1);
      if (cyc > 0 && !o_busy) begin
        idle_cyc = cyc;
        break;
      end
      if (cyc > 0) begin
        exp_idx = (nbytes / 4 > 31) ? 31 : nbytes / 4;
        if (o_read_register_1 !== 5'(exp_idx) || o_read_register_2 !== 5'(exp_idx)) begin
          chk("addr_mux_r1", o_read_register_1, exp_idx);
          chk("addr_mux_r2", o_read_register_2, exp_idx);
        end
      end
      if (stall_len > 0 && cyc >= stall_start && cyc < stall_start + stall_len) begin
        chk("valid_held_in_stall", o_tx_valid, 1);
        chk("byte_held_in_stall", o_tx_data, 8'hDE);
      end
      if (o_tx_valid) begin
        if (first_valid < 0) first_valid = cyc;
        word = 32'hC0DE0000 | 32'(nbytes / 4);
        exp_byte = word[8*(nbytes%4) +: 8];
        if (nbytes >= 128) chk("extra_byte", nbytes, 127);
        else if (o_tx_data !== exp_byte) chk("byte_stream", o_tx_data, exp_byte);
        if (i_tx_ready) nbytes++;
      end
      if (o_done) begin
        done_cyc = cyc;
        done_cnt++;
      end
      step();
      cyc++;
      i_start = extra_starts && (cyc == 10 || cyc == 50);
      i_tx_ready = !(stall_len > 0 && cyc >= stall_start && cyc < stall_start + stall_len);
      if (wiggle) begin
        i_pipe_read_register_1 = 5'($urandom);
        i_pipe_read_register_2 = 5'($urandom);
      end
    end
    chk("dump_terminated", (idle_cyc >= 0), 1);
    chk("byte_count", nbytes, 128);
    chk("first_valid_cycle", first_valid, 3);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", done_cnt, 1);
    chk("idle_cycle", idle_cyc, exp_done + 1);
    i_start = 1'b0;
    step();
    i_pipe_read_register_1 = 5'd7;
    i_pipe_read_register_2 = 5'd12;
    repeat (3) begin
      @(negedge clk);
      if (o_busy !== 1'b0) chk("stays_idle", o_busy, 0);
      step();
    end
    @(negedge clk);
    chk("passthrough_r1", o_read_register_1, 5'd7);
    chk("passthrough_r2", o_read_register_2, 5'd12);
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE0000 | 32'(i);
    vecs[0] = '{1'b1, 5'd7,  5'd12, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 5'd7,  5'd12, 1'b1, 5'd7,  5'd12, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 5'd3,  5'd30, 1'b1, 5'd3,  5'd30, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 5'd31, 5'd0,  1'b1, 5'd31, 5'd0,  1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 5'd0,  5'd31, 1'b1, 5'd0,  5'd31, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 5'd7,  5'd12, 1'b1, 5'd7,  5'd12, 1'b0, 1'b0, 1'b0, 8'h00};

    rst = 1'b1;
    i_start = 1'b0;
    i_tx_ready = 1'b1;
    i_pipe_read_register_1 = '0;
    i_pipe_read_register_2 = '0;
    step();
    step();
    rst = 1'b0;

    // Get traffic going, then hit it with the reset vectors
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (20) step();
    for (int v = 0; v < 6; v++) begin
      rst = vecs[v].rst;
      i_pipe_read_register_1 = vecs[v].p1;
      i_pipe_read_register_2 = vecs[v].p2;
      @(negedge clk);
      if (vecs[v].chk) begin
        chk("vec_r1", o_read_register_1, vecs[v].e1);
        chk("vec_r2", o_read_register_2, vecs[v].e2);
        chk("vec_busy", o_busy, vecs[v].busy);
        chk("vec_valid", o_tx_valid, vecs[v].valid);
        chk("vec_done", o_done, vecs[v].done);
        chk("vec_data", o_tx_data, vecs[v].data);
      end
      step();
    end
    rst = 1'b0;

    run_dump(-1, 0, 1'b0, 1'b0, 193);
    run_dump(23, 5, 1'b0, 1'b0, 198);
    run_dump(-1, 0, 1'b1, 1'b0, 193);
    run_dump(-1, 0, 1'b0, 1'b1, 193);

    // Reset while the first byte of register 9 is presented (cycle 57)
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (56) step();
    @(negedge clk);
    chk("r9_valid_before_rst", o_tx_valid, 1);
    chk("r9_byte_before_rst", o_tx_data, 8'h09);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", o_tx_valid, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    repeat (10) begin
      step();
      @(negedge clk);
      if (o_done !== 1'b0 || o_tx_valid !== 1'b0) begin
        chk("no_done_after_rst", o_done, 0);
        chk("no_valid_after_rst", o_tx_valid, 0);
      end
    end
    step();
    run_dump(-1, 0, 1'b0, 1'b0, 193);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
